// File: rtl/dlsc_axi_rdarb_if.sv
// AXI read-channel bundle (AR + R) shared by both requesters and the downstream port.
// The "master" modport is the side that issues commands; "slave" is the side that serves them.
interface dlsc_axi_rdarb_if #(
   parameter int DATA = 32,
   parameter int ADDR = 32,
   parameter int LEN  = 4,
   parameter int RESP = 2
);
   logic            ar_ready;
   logic            ar_valid;
   logic [ADDR-1:0] ar_addr;
   logic [LEN-1:0]  ar_len;
   logic            r_ready;
   logic            r_valid;
   logic            r_last;
   logic [DATA-1:0] r_data;
   logic [RESP-1:0] r_resp;

   modport master (
      input  ar_ready,
      output ar_valid, ar_addr, ar_len,
      output r_ready,
      input  r_valid, r_last, r_data, r_resp
   );

   modport slave (
      output ar_ready,
      input  ar_valid, ar_addr, ar_len,
      input  r_ready,
      output r_valid, r_last, r_data, r_resp
   );
endinterface

// File: rtl/dlsc_axi_rdarb.sv
// Two-master AXI read arbiter: round-robin AR grant into a one-entry command register,
// in-order owner FIFO recording who issued each command, combinational R steering.
module dlsc_axi_rdarb #(
   parameter int DATA            = 32,
   parameter int ADDR            = 32,
   parameter int LEN             = 4,
   parameter int RESP            = 2,
   parameter int MAX_OUTSTANDING = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dlsc_axi_rdarb_if.slave       m0,
   dlsc_axi_rdarb_if.slave       m1,
   dlsc_axi_rdarb_if.master      s
);

   localparam int CW        = $clog2(MAX_OUTSTANDING + 1);
   localparam int FW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OWN_DEPTH = 1 << FW;

   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
   localparam logic [FW-1:0] LAST_PTR = FW'(MAX_OUTSTANDING - 1);

   logic                  ar_valid_q, ar_valid_d;
   logic [ADDR-1:0]       ar_addr_q,  ar_addr_d;
   logic [LEN-1:0]        ar_len_q,   ar_len_d;
   logic                  last_q,     last_d;
   logic [CW-1:0]         count_q,    count_d;
   logic [FW-1:0]         wr_ptr_q,   wr_ptr_d;
   logic [FW-1:0]         rd_ptr_q,   rd_ptr_d;
   logic [OWN_DEPTH-1:0]  own_q,      own_d;

   logic grant;
   logic drain;
   logic can_load;
   logic load;
   logic fifo_empty;
   logic head;
   logic head_ready;
   logic r_ready;
   logic pop;

   logic [DATA-1:0] r_data;
   logic [RESP-1:0] r_resp;

   // Arbitration, load qualification and R-steering decisions
   always_comb begin
      grant = 1'b0;
      if (m0.ar_valid && m1.ar_valid) begin
         grant = ~last_q;
      end else begin
         grant = m1.ar_valid;
      end
      fifo_empty = (count_q == '0);
      head       = own_q[rd_ptr_q];
      head_ready = head ? m1.r_ready : m0.r_ready;
      r_ready    = !fifo_empty && head_ready;
      pop        = s.r_valid && r_ready && s.r_last;
      drain      = ar_valid_q && s.ar_ready;
      // a final-beat pop frees its slot in the same cycle, so a full arbiter can still load
      can_load   = rst_n && (!ar_valid_q || drain) && ((count_q != MAX_CNT) || pop);
      load       = can_load && (m0.ar_valid || m1.ar_valid);
   end

   assign m0.ar_ready = can_load && m0.ar_valid && !grant;
   assign m1.ar_ready = can_load && m1.ar_valid &&  grant;

   assign s.ar_valid  = ar_valid_q;
   assign s.ar_addr   = ar_addr_q;
   assign s.ar_len    = ar_len_q;

   assign s.r_ready   = r_ready;
   assign m0.r_valid  = s.r_valid && !fifo_empty && !head;
   assign m1.r_valid  = s.r_valid && !fifo_empty &&  head;

   assign r_data      = s.r_data;
   assign r_resp      = s.r_resp;
   assign m0.r_data   = r_data;
   assign m1.r_data   = r_data;
   assign m0.r_resp   = r_resp;
   assign m1.r_resp   = r_resp;
   assign m0.r_last   = s.r_last;
   assign m1.r_last   = s.r_last;

   // Next state for command register, round-robin pointer, owner FIFO and outstanding count
   always_comb begin
      ar_valid_d = ar_valid_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      last_d     = last_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      own_d      = own_q;
      if (drain) begin
         ar_valid_d = 1'b0;
      end
      if (load) begin
         ar_valid_d      = 1'b1;
         ar_addr_d       = grant ? m1.ar_addr : m0.ar_addr;
         ar_len_d        = grant ? m1.ar_len  : m0.ar_len;
         last_d          = grant;
         own_d[wr_ptr_q] = grant;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({load, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards any outstanding bursts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         last_q     <= 1'b1;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         own_q      <= '0;
      end else begin
         ar_valid_q <= ar_valid_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         last_q     <= last_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         own_q      <= own_d;
      end
   end

endmodule

// File: tb/tb_dlsc_axi_rdarb.sv
// Directed bench for dlsc_axi_rdarb: AR and R scoreboards filled as stimulus is driven,
// drained by a monitor that samples handshakes just before each rising edge.
module tb_dlsc_axi_rdarb;

   localparam int MAXO = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   dlsc_axi_rdarb_if m0_if ();
   dlsc_axi_rdarb_if m1_if ();
   dlsc_axi_rdarb_if s_if ();

   dlsc_axi_rdarb #(
      .DATA(32), .ADDR(32), .LEN(4), .RESP(2), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if)
   );

   typedef struct { logic [31:0] addr; logic [3:0] len; } ar_t;
   typedef struct { bit owner; logic [3:0] len; } cmd_t;
   typedef struct { bit owner; logic [31:0] data; logic [1:0] resp; bit last; } r_t;

   ar_t  arq[$];
   cmd_t cmdq[$];
   r_t   rq[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit model_last = 1'b1;

   ar_t mon_ar;
   r_t  mon_r;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: compare downstream AR and steered R handshakes against the scoreboards
   always begin
      @(negedge clk);
      #4;
      if (rst_n) begin
         if (s_if.ar_valid && s_if.ar_ready) begin
            check("ar_expected", 64'(arq.size() != 0), 1);
            if (arq.size() != 0) begin
               mon_ar = arq.pop_front();
               check("s_ar_addr", s_if.ar_addr, mon_ar.addr);
               check("s_ar_len", s_if.ar_len, mon_ar.len);
            end
         end
         if (s_if.r_valid && s_if.r_ready) begin
            check("r_expected", 64'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               mon_r = rq.pop_front();
               check("r_valid_owner", mon_r.owner ? m1_if.r_valid : m0_if.r_valid, 1);
               check("r_valid_other", mon_r.owner ? m0_if.r_valid : m1_if.r_valid, 0);
               check("r_data", mon_r.owner ? m1_if.r_data : m0_if.r_data, mon_r.data);
               check("r_resp", mon_r.owner ? m1_if.r_resp : m0_if.r_resp, mon_r.resp);
               check("r_last", mon_r.owner ? m1_if.r_last : m0_if.r_last, mon_r.last);
            end
         end
      end
   end

   // Issue one command from a single master; called at a falling edge, returns at one
   task automatic issue(input bit m, input logic [31:0] addr, input logic [3:0] len);
      if (m) begin
         m1_if.ar_valid = 1'b1; m1_if.ar_addr = addr; m1_if.ar_len = len;
      end else begin
         m0_if.ar_valid = 1'b1; m0_if.ar_addr = addr; m0_if.ar_len = len;
      end
      #1;
      check(m ? "m1_ar_ready" : "m0_ar_ready", m ? m1_if.ar_ready : m0_if.ar_ready, 1);
      check("other_ar_ready", m ? m0_if.ar_ready : m1_if.ar_ready, 0);
      arq.push_back('{addr, len});
      cmdq.push_back('{m, len});
      model_last = m;
      @(negedge clk);
      m0_if.ar_valid = 1'b0;
      m1_if.ar_valid = 1'b0;
      #1;
      check("s_ar_valid_latency", s_if.ar_valid, 1);
      @(negedge clk);
   endtask

   // Return beats for the oldest outstanding command; toggle=1 wiggles the owner's r_ready
   task automatic send_burst(input bit toggle, input int stop_beats);
      cmd_t c;
      r_t   b;
      int   cyc;
      bit   rdy;
      bit   done;
      cyc = 0;
      check("cmd_outstanding", 64'(cmdq.size() != 0), 1);
      if (cmdq.size() == 0) return;
      c = cmdq[0];
      for (int i = 0; i <= int'(c.len) && i < stop_beats; i++) begin
         b.owner = c.owner;
         b.data  = $urandom;
         b.resp  = 2'($urandom_range(0, 3));
         b.last  = (i == int'(c.len));
         s_if.r_valid = 1'b1;
         s_if.r_data  = b.data;
         s_if.r_resp  = b.resp;
         s_if.r_last  = b.last;
         rq.push_back(b);
         done = 1'b0;
         for (int k = 0; k < 40 && !done; k++) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            cyc++;
            if (c.owner) begin
               m1_if.r_ready = rdy; m0_if.r_ready = 1'b1;
            end else begin
               m0_if.r_ready = rdy; m1_if.r_ready = 1'b1;
            end
            #1;
            check("s_r_ready_mirror", s_if.r_ready, rdy);
            check("owner_r_valid", c.owner ? m1_if.r_valid : m0_if.r_valid, 1);
            check("other_r_valid", c.owner ? m0_if.r_valid : m1_if.r_valid, 0);
            done = s_if.r_ready;
            @(negedge clk);
         end
         check("r_beat_accepted", done, 1);
      end
      s_if.r_valid = 1'b0;
      s_if.r_last  = 1'b0;
      m0_if.r_ready = 1'b1;
      m1_if.r_ready = 1'b1;
      if (stop_beats > int'(c.len)) void'(cmdq.pop_front());
   endtask

   // A beat with no outstanding command must stall and reach neither master
   task automatic stray_check();
      s_if.r_valid = 1'b1;
      s_if.r_last  = 1'b1;
      #1;
      check("stray_s_r_ready", s_if.r_ready, 0);
      check("stray_m0_r_valid", m0_if.r_valid, 0);
      check("stray_m1_r_valid", m1_if.r_valid, 0);
      @(negedge clk);
      check("stray_s_r_ready_hold", s_if.r_ready, 0);
      s_if.r_valid = 1'b0;
      s_if.r_last  = 1'b0;
   endtask

   logic [31:0] a0_tbl [2];
   logic [3:0]  l0_tbl [2];
   logic [31:0] a1_tbl [2];
   logic [3:0]  l1_tbl [2];

   initial begin
      int  i0;
      int  i1;
      bit  g;
      int  acc;
      a0_tbl = '{32'h1000, 32'h1010};
      l0_tbl = '{4'd0, 4'd2};
      a1_tbl = '{32'h2000, 32'h2010};
      l1_tbl = '{4'd1, 4'd0};

      m0_if.ar_valid = 1'b1; m0_if.ar_addr = 32'hdead; m0_if.ar_len = 4'd0; m0_if.r_ready = 1'b1;
      m1_if.ar_valid = 1'b0; m1_if.ar_addr = '0;       m1_if.ar_len = 4'd0; m1_if.r_ready = 1'b1;
      s_if.ar_ready = 1'b1;
      s_if.r_valid = 1'b0; s_if.r_last = 1'b0; s_if.r_data = '0; s_if.r_resp = '0;

      // reset state
      @(negedge clk);
      #1;
      check("rst_s_ar_valid", s_if.ar_valid, 0);
      check("rst_s_ar_addr", s_if.ar_addr, 0);
      check("rst_s_ar_len", s_if.ar_len, 0);
      check("rst_m0_ar_ready", m0_if.ar_ready, 0);
      check("rst_m1_ar_ready", m1_if.ar_ready, 0);
      check("rst_s_r_ready", s_if.r_ready, 0);
      check("rst_m0_r_valid", m0_if.r_valid, 0);
      m0_if.ar_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // contention: both request every cycle, grants alternate starting with m0
      i0 = 0; i1 = 0;
      for (int k = 0; k < 4; k++) begin
         m0_if.ar_valid = 1'b1;
         m0_if.ar_addr  = (i0 < 2) ? a0_tbl[i0] : 32'h0;
         m0_if.ar_len   = (i0 < 2) ? l0_tbl[i0] : 4'd0;
         m1_if.ar_valid = 1'b1;
         m1_if.ar_addr  = (i1 < 2) ? a1_tbl[i1] : 32'h0;
         m1_if.ar_len   = (i1 < 2) ? l1_tbl[i1] : 4'd0;
         #1;
         g = ~model_last;
         check("cont_m0_ar_ready", m0_if.ar_ready, !g);
         check("cont_m1_ar_ready", m1_if.ar_ready, g);
         if (k > 0) check("cont_s_ar_valid", s_if.ar_valid, 1);
         if (g) begin
            arq.push_back('{a1_tbl[i1], l1_tbl[i1]});
            cmdq.push_back('{1'b1, l1_tbl[i1]});
            i1++;
         end else begin
            arq.push_back('{a0_tbl[i0], l0_tbl[i0]});
            cmdq.push_back('{1'b0, l0_tbl[i0]});
            i0++;
         end
         model_last = g;
         @(negedge clk);
      end
      m0_if.ar_valid = 1'b0;
      m1_if.ar_valid = 1'b0;
      #1;
      check("cont_s_ar_valid_tail", s_if.ar_valid, 1);
      @(negedge clk);
      for (int k = 0; k < 4; k++) send_burst(1'b0, 16);
      check("cont_arq_drained", 64'(arq.size()), 0);

      // single read: m0 addr 0x100 len 3
      issue(1'b0, 32'h100, 4'd3);
      send_burst(1'b0, 16);
      stray_check();

      // full: m1 streams len-0 reads with no R traffic
      m1_if.ar_valid = 1'b1; m1_if.ar_addr = 32'h3000; m1_if.ar_len = 4'd0;
      acc = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (m1_if.ar_ready) begin
            arq.push_back('{m1_if.ar_addr, 4'd0});
            cmdq.push_back('{1'b1, 4'd0});
            model_last = 1'b1;
            acc++;
         end
         @(negedge clk);
         m1_if.ar_addr = 32'h3000 + 32'(acc * 16);
      end
      check("full_accepted", 64'(acc), MAXO);
      #1;
      check("full_m1_ar_ready", m1_if.ar_ready, 0);
      @(negedge clk);
      m1_if.ar_valid = 1'b0;
      m0_if.ar_valid = 1'b1; m0_if.ar_addr = 32'h4000; m0_if.ar_len = 4'd5;
      #1;
      check("full_m0_ar_ready", m0_if.ar_ready, 0);
      @(negedge clk);
      // final beat and new load in the same cycle at count == MAX
      mon_r.owner = cmdq[0].owner; mon_r.data = 32'h0bad_f00d; mon_r.resp = 2'd1; mon_r.last = 1'b1;
      s_if.r_valid = 1'b1; s_if.r_last = 1'b1; s_if.r_data = 32'h0bad_f00d; s_if.r_resp = 2'd1;
      rq.push_back(mon_r);
      #1;
      check("pop_s_r_ready", s_if.r_ready, 1);
      check("pop_m0_ar_ready_reassert", m0_if.ar_ready, 1);
      arq.push_back('{32'h4000, 4'd5});
      void'(cmdq.pop_front());
      cmdq.push_back('{1'b0, 4'd5});
      model_last = 1'b0;
      @(negedge clk);
      s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
      m0_if.ar_addr = 32'h4100;
      #1;
      check("one_slot_only_m0", m0_if.ar_ready, 0);
      @(negedge clk);
      m0_if.ar_valid = 1'b0;
      for (int k = 0; k < 20 && cmdq.size() != 0; k++) send_burst(1'b0, 16);
      check("full_cmdq_drained", 64'(cmdq.size()), 0);
      stray_check();

      // backpressure: len-7 burst owned by m1 with toggling r_ready
      issue(1'b1, 32'h5000, 4'd7);
      send_burst(1'b1, 16);
      stray_check();

      // reset mid-burst
      issue(1'b0, 32'h6000, 4'd3);
      send_burst(1'b0, 1);
      s_if.ar_ready = 1'b0;
      m1_if.ar_valid = 1'b1; m1_if.ar_addr = 32'h7000; m1_if.ar_len = 4'd0;
      #1;
      check("pre_rst_m1_ar_ready", m1_if.ar_ready, 1);
      @(negedge clk);
      m1_if.ar_valid = 1'b0;
      m0_if.ar_valid = 1'b1;
      s_if.r_valid = 1'b1; s_if.r_last = 1'b0; s_if.r_data = 32'h2222;
      #1;
      check("pre_rst_s_ar_valid", s_if.ar_valid, 1);
      check("pre_rst_m0_r_valid", m0_if.r_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_s_ar_valid", s_if.ar_valid, 0);
      check("mid_rst_m0_r_valid", m0_if.r_valid, 0);
      check("mid_rst_m1_r_valid", m1_if.r_valid, 0);
      check("mid_rst_s_r_ready", s_if.r_ready, 0);
      check("mid_rst_m0_ar_ready", m0_if.ar_ready, 0);
      check("mid_rst_m1_ar_ready", m1_if.ar_ready, 0);
      arq.delete(); cmdq.delete(); rq.delete();
      model_last = 1'b1;
      @(negedge clk);
      s_if.r_valid = 1'b0;
      m0_if.ar_valid = 1'b0;
      s_if.ar_ready = 1'b1;
      rst_n = 1'b1;
      stray_check();
      check("post_rst_s_ar_valid", s_if.ar_valid, 0);
      issue(1'b1, 32'h8000, 4'd1);
      send_burst(1'b0, 16);
      stray_check();
      check("final_arq_empty", 64'(arq.size()), 0);
      check("final_rq_empty", 64'(rq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dlsc_axi_rdarb.md
# dlsc_axi_rdarb

Two-master AXI read-channel arbiter that shares a single read port, such as the master side of the AXI reset-crossing bridge, between two requesters. AR commands from masters 0 and 1 are arbitrated round-robin and forwarded through a one-entry register. The issuing master of every forwarded command is recorded in an in-order owner FIFO. R beats from the slave port are steered back to the owning master. No IDs are used: the downstream port returns read bursts in command order.

## Interface
Parameters:
- DATA, 32, read data width
- ADDR, 32, address width
- LEN, 4, burst length field width (beats = len+1)
- RESP, 2, response width
- MAX_OUTSTANDING, 15, max commands accepted but not yet completed by last R beat; also owner FIFO depth; range 1..255

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_ar_ready / m1_ar_ready  out  1  command accepted from master 0 / 1
- m0_ar_valid / m1_ar_valid  in  1  command request
- m0_ar_addr / m1_ar_addr  in  ADDR  address
- m0_ar_len / m1_ar_len  in  LEN  burst length
- m0_r_ready / m1_r_ready  in  1  master accepts beat
- m0_r_valid / m1_r_valid  out  1  beat for master 0 / 1
- m0_r_last / m1_r_last  out  1  last beat
- m0_r_data / m1_r_data  out  DATA  beat data
- m0_r_resp / m1_r_resp  out  RESP  beat response
- s_ar_ready  in  1  downstream accepts command
- s_ar_valid  out  1  command valid
- s_ar_addr  out  ADDR  address
- s_ar_len  out  LEN  length
- s_r_ready  out  1  beat accepted
- s_r_valid  in  1  beat valid
- s_r_last  in  1  last beat
- s_r_data  in  DATA  data
- s_r_resp  in  RESP  response

## Operation
- AR register holds one command plus valid bit. It loads when empty or drained this cycle (s_ar_valid && s_ar_ready) and count < MAX_OUTSTANDING.
- Arbitration (combinational):
  - Candidates are masters with ar_valid.
  - If both request, grant the master not granted last (pointer `last`).
  - Exactly one mX_ar_ready is high, and only in a load cycle, for the granted master.
  - `last` updates to the granted index on load.
- On load:
  - Push the granted index into the owner FIFO.
  - Capture addr/len into the AR register.
  - count += 1.
- R steering:
  - head = owner FIFO head; fifo_empty = count of FIFO entries is 0.
  - mX_r_valid = s_r_valid && !fifo_empty && head==X.
  - s_r_ready = !fifo_empty && m[head]_r_ready.
  - r_data, r_resp and r_last are broadcast to both masters unqualified.
- Completion: on s_r_valid && s_r_ready && s_r_last, pop the FIFO and count -= 1.
- Simultaneous load and completion: count unchanged; the FIFO push and pop both take effect.
- count width is clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING and never underflows, because pop requires a non-empty FIFO.
- R beat arriving with an empty FIFO (protocol violation): s_r_ready=0, the beat stalls, no master sees valid.
- Reset (rst_n low, asynchronous):
  - s_ar_valid=0, s_ar_addr=0, s_ar_len=0.
  - FIFO empty, count=0, `last`=1 (so master 0 wins the first tie).
  - All mX_ar_ready=0, mX_r_valid=0, s_r_ready=0.
  - Outstanding bursts are discarded.

## Timing
- AR latency: handshake on mX_ar at cycle N gives s_ar_valid at N+1. Back-to-back throughput is one command per cycle while s_ar_ready stays high.
- mX_ar_ready depends combinationally on s_ar_ready, AR register state, count, and mX_ar_valid.
- R path has zero latency (combinational). The beat reaches the master in the same cycle, and backpressure passes straight through.
- At count==MAX_OUTSTANDING: both ar_ready are low. They reassert in the same cycle as the final-beat pop.
- After rst_n deasserts, the first load can occur in the first clk edge.

## Test plan
- Single read: m0 addr 0x100 len 3, slave returns 4 beats -> s_ar_valid one cycle after handshake, 4 beats on m0 only, last on beat 4, count back to 0.
- Contention: both masters valid every cycle, s_ar_ready=1 -> grants alternate m0,m1,m0,m1 starting with m0. R bursts (len 0, 1, 2, 0) route to m0,m1,m0,m1 in order.
- Full: MAX_OUTSTANDING=15, s_r_valid held 0, m1 streams len-0 reads -> exactly 15 accepted, then m1_ar_ready=0. One last beat then frees exactly one slot in that same cycle.
- Backpressure: m1_r_ready toggles 1/0 during a len-7 burst owned by m1 -> s_r_ready mirrors it, m0_r_valid stays 0, all 8 beats arrive in order.
- Simultaneous push/pop at count=15: load and final beat in one cycle -> count remains 15, FIFO order intact.
- Reset mid-burst: rst_n low during beat 2 of 4 -> all valids/readies 0 immediately. After release, a new m1 read completes normally, and a stray s_r_valid before any command is not accepted.
